fetch_prefetch: RTL

Instruction prefetch unit for the in-order pipeline. It drives the instruction-memory request/response port and keeps several requests in flight. Returned instructions are buffered with their PCs in an internal FIFO that feeds the IF->ID pipeline register. On a control hazard from the MEM stage it flushes its state, redirects the PC, and silently drops responses still in flight for the old path.

---
 rtl/fetch_prefetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: credit-limited memory requests, in-order response FIFO, redirect
// with in-flight discard. Optional FETCH_BYPASS_EN forwards a response straight to the consumer.
module fetch_prefetch #(
  parameter int unsigned     Xlen    = 64,
  parameter int unsigned     Ilen    = 32,
  parameter int unsigned     Depth   = 4,
  parameter logic [Xlen-1:0] ResetPc = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            control_hazard_i,
  input  logic [Xlen-1:0] pc_target_i,
  input  logic            mem_ready_i,
  output logic            mem_valid_o,
  output logic [Xlen-1:0] mem_addr_o,
  input  logic [Xlen-1:0] mem_rdata_i,
  input  logic            mem_rvalid_i,
  input  logic            inst_ready_i,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o,
  output logic            inst_valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW+1)'(Depth);

  typedef logic [CntW-1:0] cnt_t;

  logic [Xlen-1:0] req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
  cnt_t            inflight_q, inflight_d, discard_q, discard_d, count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Xlen-1:0] pc_mem   [Depth];
  logic [Ilen-1:0] data_mem [Depth];

  logic            req_fire, resp_keep, push, fifo_pop, bypass;
  logic [CntW:0]   occupancy;
  logic [Xlen-1:0] redirect_pc;
  logic            unused_rdata;

  assign unused_rdata = ^mem_rdata_i[Xlen-1:Ilen];
  assign redirect_pc  = {pc_target_i[Xlen-1:2], 2'b00};

  // Buffered plus in-flight entries never exceed Depth, so the FIFO cannot overflow.
  assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
  assign mem_valid_o = rst_ni && !control_hazard_i && (occupancy < DepthOcc);
  assign mem_addr_o  = req_pc_q;
  assign req_fire    = mem_valid_o && mem_ready_i;
  assign resp_keep   = mem_rvalid_i && (discard_q == '0) && !control_hazard_i;

`ifdef FETCH_BYPASS_EN
  assign bypass       = (count_q == '0) && resp_keep;
  assign inst_valid_o = ((count_q != '0) && !control_hazard_i) || bypass;
  assign inst_pc_o    = bypass ? resp_pc_q : pc_mem[rd_ptr_q];
  assign inst_data_o  = bypass ? mem_rdata_i[Ilen-1:0] : data_mem[rd_ptr_q];
`else
  assign bypass       = 1'b0;
  assign inst_valid_o = (count_q != '0) && !control_hazard_i;
  assign inst_pc_o    = pc_mem[rd_ptr_q];
  assign inst_data_o  = data_mem[rd_ptr_q];
`endif

  assign fifo_pop = inst_valid_o && inst_ready_i && !bypass;
  assign push     = resp_keep && !(bypass && inst_ready_i);

  always_comb begin
    req_pc_d   = req_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(mem_rvalid_i);

    if (control_hazard_i) begin
      // Everything still outstanding after this edge belongs to the old path.
      req_pc_d  = redirect_pc;
      resp_pc_d = redirect_pc;
      discard_d = inflight_d;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (req_fire) req_pc_d = req_pc_q + Xlen'(4);
      if (mem_rvalid_i && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
      if (resp_keep) resp_pc_d = resp_pc_q + Xlen'(4);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(fifo_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc_q   <= ResetPc;
      resp_pc_q  <= ResetPc;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      data_mem[wr_ptr_q] <= mem_rdata_i[Ilen-1:0];
    end
  end

  rvalid_needs_inflight: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (inflight_q != '0));

endmodule
